fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//   Program counter / next-PC stage that directly consumes the ALU's branch results (Out, Zero).
//   - Holds the PC and resolves conditional branches (BEQ/BNE/BLE/BLT) and JUMP into the next fetch address.
//   - Branch targets come from a writable target LUT indexed by the 5-bit immediate.
//   - Sequences program start, halt and done for the top level.
// PARAMETERS
//   PC_W       10  width of PC / instruction address (bits)
//   LUT_DEPTH  32  number of branch-target LUT entries (indexed by 5-bit Imm; must be <= 32)
// PORTS
//   CLK        in   1       system clock, all state updates on rising edge
//   Reset_n    in   1       synchronous active-low reset
//   Start      in   1       1-cycle pulse: load StartAddr into PC, enter RUN
//   StartAddr  in   PC_W    program entry address
//   Stall      in   1       hold PC and state this cycle (Start and Reset_n still act)
//   BranchEn   in   1       current instruction is a conditional branch (from decode)
//   JumpEn     in   1       current instruction is an unconditional JUMP (from decode)
//   Halt       in   1       current instruction is the halt op (from decode)
//   AluOut     in   8       ALU result; bit 0 = branch condition true
//   AluZero    in   1       ALU zero flag
//   TargetIdx  in   5       branch/jump immediate (LUT index)
//   LutWe      in   1       target LUT write enable
//   LutWAddr   in   5       target LUT write index
//   LutWData   in   PC_W    target LUT write data
//   PC         out  PC_W    current fetch address
//   Running    out  1       1 while in RUN
//   Done       out  1       1 while in DONE
//   BranchCnt  out  16      taken branch/jump count (see CONFIGURATION)
// BEHAVIOUR
//   Reset (Reset_n=0 at edge): state=IDLE, PC=0, Running=0, Done=0, BranchCnt=0, all LUT entries=0; overrides everything.
//   FSM states: IDLE, RUN, DONE.
//   - Start=1 in any state: PC<=StartAddr, state<=RUN, BranchCnt<=0. Start has priority over Stall/Halt/branch.
//   - IDLE: PC held; no Start -> stay IDLE.
//   - RUN, Stall=1: PC, state and counter held.
//   - RUN, Stall=0, evaluated in priority order:
//     - Halt=1 -> DONE, PC held (Halt beats a simultaneous branch/jump).
//     - JumpEn=1 -> PC<=LUT[TargetIdx].
//     - BranchEn=1 and taken -> PC<=LUT[TargetIdx]. Taken = AluOut[0]=1, equivalently AluZero=0; the two must agree.
//     - Otherwise PC<=PC+1, modulo 2^PC_W (max value wraps to 0).
//   - DONE: PC held, Done=1; leaves only on Start or reset.
//   Both enables set: JumpEn wins, treated as a single taken redirect.
//   Outputs are registered/state-decoded. Next PC is visible 1 cycle after the deciding inputs, so latency = 1.
//   TargetIdx >= LUT_DEPTH reads 0.
//   LUT: synchronous write, combinational read.
//   - Same-cycle write and read of the same index returns the OLD entry; the new value is visible next cycle.
//   - Writes are allowed in every state, including under Stall.
//   - LutWAddr >= LUT_DEPTH: write ignored.
// CONFIGURATION
//   FETCH_BRANCH_COUNT_EN defined:
//   - BranchCnt increments once per taken redirect (JumpEn or taken BranchEn) in RUN with Stall=0.
//   - Saturates at 16'hFFFF; cleared on Start and reset.
//   Not defined: BranchCnt tied to 0, no counter flops.
// TESTING
//   Reset_n=0 for 2 cycles mid-RUN at PC=37 -> next edge PC=0, IDLE, Running=0, Done=0, LUT[3] reads 0.
//   Start, StartAddr=5, 4 plain cycles -> PC 5,6,7,8,9; Running=1 throughout.
//   LUT[2]=40. In RUN: BranchEn=1, TargetIdx=2, AluOut=1 -> PC=40.
//     Next, BranchEn=1, AluOut=0, AluZero=1 -> PC=41.
//   PC=1023 (PC_W=10), no branch -> PC=0.
//     Then Halt=1 with JumpEn=1 -> DONE, PC stays 0, Done=1.
//     Then Start, StartAddr=8 -> PC=8, Running=1, Done=0.
//   Stall=1 with JumpEn=1 for 3 cycles -> PC unchanged.
//     Same cycle LutWe at idx 4=99 and jump via idx 4 (Stall=0) -> PC gets old value.
//   With FETCH_BRANCH_COUNT_EN: 3 jumps + 1 not-taken branch -> BranchCnt=3.
//     Start -> 0. Without the macro: BranchCnt stays 0.

Source files
------------

// File: rtl/fetch_pc_if.sv
// fetch_pc_if: bundle of decode/ALU/LUT-write inputs and PC/status outputs of the fetch stage.
//   master modport: the driver side (decode, ALU, top-level control).
//   slave modport:  fetch_pc_unit.
//   Inputs to the unit:  Start, StartAddr, Stall, BranchEn, JumpEn, Halt, AluOut, AluZero,
//                        TargetIdx, LutWe, LutWAddr, LutWData.
//   Outputs of the unit: PC, Running, Done, BranchCnt.
interface fetch_pc_if #(
  parameter int unsigned PC_W = 10
);
  logic            Start;
  logic [PC_W-1:0] StartAddr;
  logic            Stall;
  logic            BranchEn;
  logic            JumpEn;
  logic            Halt;
  logic [7:0]      AluOut;
  logic            AluZero;
  logic [4:0]      TargetIdx;
  logic            LutWe;
  logic [4:0]      LutWAddr;
  logic [PC_W-1:0] LutWData;
  logic [PC_W-1:0] PC;
  logic            Running;
  logic            Done;
  logic [15:0]     BranchCnt;

  modport master (
    output Start, StartAddr, Stall, BranchEn, JumpEn, Halt, AluOut, AluZero,
           TargetIdx, LutWe, LutWAddr, LutWData,
    input  PC, Running, Done, BranchCnt
  );

  modport slave (
    input  Start, StartAddr, Stall, BranchEn, JumpEn, Halt, AluOut, AluZero,
           TargetIdx, LutWe, LutWAddr, LutWData,
    output PC, Running, Done, BranchCnt
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter / next-PC stage.
//   Holds the PC, resolves JUMP and conditional branches (taken when AluOut[0]=1) through a
//   writable branch-target LUT indexed by the 5-bit immediate, and sequences IDLE/RUN/DONE.
// Ports:
//   CLK      - clock, all state on rising edge
//   Reset_n  - synchronous active-low reset (PC, state, counter and every LUT entry to 0)
//   bus      - fetch_pc_if.slave: Start/StartAddr/Stall/BranchEn/JumpEn/Halt/AluOut/AluZero/
//              TargetIdx/LutWe/LutWAddr/LutWData in; PC/Running/Done/BranchCnt out
// Configuration macro: FETCH_BRANCH_COUNT_EN - when defined, BranchCnt counts taken redirects
//   (saturating at 16'hFFFF, cleared on Start); otherwise BranchCnt is tied to 0.
module fetch_pc_unit #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned LUT_DEPTH = 32
) (
  input logic       CLK,
  input logic       Reset_n,
  fetch_pc_if.slave bus
);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] lut_rd;
  logic            taken;
  logic            redirect;

  // AluZero is the complement of AluOut[0] by contract, so only bit 0 is consulted.
  logic unused_alu;
  assign unused_alu = ^{bus.AluOut[7:1], bus.AluZero};
  assign taken      = bus.AluOut[0];

  // Combinational read; out-of-range indices read as zero.
  always_comb begin
    lut_rd = '0;
    if (32'(bus.TargetIdx) < LUT_DEPTH) lut_rd = lut_q[bus.TargetIdx];
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redirect = 1'b0;
    if (bus.Start) begin
      pc_d    = bus.StartAddr;
      state_d = StRun;
    end else if (state_q == StRun && !bus.Stall) begin
      if (bus.Halt) begin
        state_d = StDone;
      end else if (bus.JumpEn || (bus.BranchEn && taken)) begin
        pc_d     = lut_rd;
        redirect = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Writes land at the edge, so a same-cycle read of that index still sees the old entry.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(LUT_DEPTH); i++) lut_q[i] <= '0;
    end else if (bus.LutWe && 32'(bus.LutWAddr) < LUT_DEPTH) begin
      lut_q[bus.LutWAddr] <= bus.LutWData;
    end
  end

  assign bus.PC      = pc_q;
  assign bus.Running = (state_q == StRun);
  assign bus.Done    = (state_q == StDone);

`ifdef FETCH_BRANCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.Start)                        cnt_d = '0;
    else if (redirect && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.BranchCnt = cnt_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
  assign bus.BranchCnt   = '0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: the driver computes the expected post-edge outputs with a
// behavioural model and queues them; a monitor checks each queued entry 1 ns after the edge.
module tb_fetch_pc_unit;
  localparam int PcW   = 10;
  localparam int PcMod = 1 << PcW;

  typedef enum {MIdle, MRun, MDone} mode_e;
  typedef struct {
    int pc;
    bit running;
    bit done;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_pc_if #(.PC_W(PcW)) bus ();

  fetch_pc_unit #(.PC_W(PcW), .LUT_DEPTH(32)) u_dut (
    .CLK    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int    m_pc   = 0;
  mode_e m_mode = MIdle;
  int    m_cnt  = 0;
  int    m_lut [32];
  exp_t  sb [$];

`ifdef FETCH_BRANCH_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the expected outputs after the next edge.
  task automatic drive(input bit rst, input bit start, input int saddr, input bit stall,
                       input bit br, input bit jmp, input bit halt, input bit tk,
                       input int idx, input bit we, input int waddr, input int wdata);
    exp_t e;
    int   target;
    @(negedge clk);
    rst_n         = ~rst;
    bus.Start     = start;
    bus.StartAddr = PcW'(saddr);
    bus.Stall     = stall;
    bus.BranchEn  = br;
    bus.JumpEn    = jmp;
    bus.Halt      = halt;
    bus.AluOut    = {7'($urandom), tk};
    bus.AluZero   = ~tk;
    bus.TargetIdx = 5'(idx);
    bus.LutWe     = we;
    bus.LutWAddr  = 5'(waddr);
    bus.LutWData  = PcW'(wdata);
    if (rst) begin
      m_pc = 0; m_mode = MIdle; m_cnt = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
    end else begin
      target = m_lut[idx % 32];
      if (start) begin
        m_pc = saddr % PcMod; m_mode = MRun; m_cnt = 0;
      end else if (m_mode == MRun && !stall) begin
        if (halt) m_mode = MDone;
        else if (jmp || (br && tk)) begin
          m_pc = target;
          if (m_cnt < 65535) m_cnt++;
        end else m_pc = (m_pc + 1) % PcMod;
      end
      if (we) m_lut[waddr % 32] = wdata % PcMod;
    end
    e.pc = m_pc; e.running = (m_mode == MRun); e.done = (m_mode == MDone);
    e.cnt = CountEn ? m_cnt : 0;
    sb.push_back(e);
  endtask

  task automatic plain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Direct check against a constant right after the edge that follows the last drive.
  task automatic expect_pc(input string name, input int req);
    @(posedge clk);
    #2;
    check(name, int'(bus.PC), req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_pc", int'(bus.PC), e.pc);
        check("sb_running", int'(bus.Running), int'(e.running));
        check("sb_done", int'(bus.Done), int'(e.done));
        check("sb_cnt", int'(bus.BranchCnt), e.cnt);
      end
    end
  end

  initial begin : stim
    int waited;
    rst_n = 1'b0;
    bus.Start = 0; bus.StartAddr = '0; bus.Stall = 0; bus.BranchEn = 0; bus.JumpEn = 0;
    bus.Halt = 0; bus.AluOut = '0; bus.AluZero = 1; bus.TargetIdx = '0; bus.LutWe = 0;
    bus.LutWAddr = '0; bus.LutWData = '0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_pc("reset_pc", 0);
    // Mid-run reset at PC=37
    drive(0, 1, 37, 0, 0, 0, 0, 0, 0, 1, 3, 77);
    expect_pc("start37", 37);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_pc("midrun_reset", 0);
    // LUT[2]=40 while idle, then start at 5 and run 4 plain cycles
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 40);
    drive(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_pc("start5", 5);
    for (int i = 1; i <= 4; i++) begin
      plain();
      expect_pc("seq", 5 + i);
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0);
    expect_pc("lut3_cleared", 0);
    drive(0, 0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 0);
    expect_pc("br_taken", 40);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0);
    expect_pc("br_not_taken", 41);
    // Wrap, halt beating jump, restart
    drive(0, 1, 1023, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    plain();
    expect_pc("wrap", 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0);
    expect_pc("halt_hold", 0);
    plain();
    expect_pc("done_hold", 0);
    drive(0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_pc("restart8", 8);
    // Stall holds despite jump
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 1, 0, 0, 2, 0, 0, 0);
    expect_pc("stall_hold", 8);
    // Same-cycle write/read of LUT[4] sees old value (0)
    drive(0, 0, 0, 0, 0, 1, 0, 0, 4, 1, 4, 99);
    expect_pc("lut_old", 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 4, 0, 0, 0);
    expect_pc("lut_new", 99);
    // Counter: 3 jumps + 1 not-taken branch, then Start clears
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0);
    expect_pc("cnt_seq_pc", 41);
    check("cnt3", int'(bus.BranchCnt), CountEn ? 3 : 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_pc("cnt_start_pc", 0);
    check("cnt_clear", int'(bus.BranchCnt), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) < 2, $urandom_range(99) < 4, int'($urandom_range(PcMod - 1)),
            $urandom_range(99) < 20, $urandom_range(99) < 30, $urandom_range(99) < 15,
            $urandom_range(99) < 3, $urandom_range(1), int'($urandom_range(31)),
            $urandom_range(99) < 25, int'($urandom_range(31)),
            int'($urandom_range(PcMod - 1)));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
